// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, funct3 codes and access-legality helpers
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; everything else outside B/H/W is undefined.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !wr;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and word-memory bus bundle
interface lsu_if #(
    parameter int ADDR_W = 32
) ();
    // core side
    logic              req;
    logic              wr;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic              busy;
    // memory side
    logic [ADDR_W-1:0] A;
    logic [31:0]       WD;
    logic              WE;
    logic [31:0]       RD;

    // The load/store unit sits on the slave port; core plus memory model drive the master port.
    modport slave (
        input  req, wr, funct3, addr, wdata, RD,
        output rdata, done, err, busy, A, WD, WE
    );

    modport master (
        output req, wr, funct3, addr, wdata, RD,
        input  rdata, done, err, busy, A, WD, WE
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and store lane merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rd_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        byte_lane = rd_i[{off_i, 3'b000} +: 8];
        half_lane = off_i[1] ? rd_i[31:16] : rd_i[15:0];
        load_o    = rd_i;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_o = {24'h0, byte_lane};
            F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_o = {16'h0, half_lane};
            default: load_o = rd_i;
        endcase
    end

    // Overlay the low store bits onto the old word; word stores pass straight through.
    always_comb begin
        merge_o = old_i;
        case (funct3_i[1:0])
            2'b00: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access load/store sequencer over a word-wide memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    state_t            state_q, state_d;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .rd_i     (bus.RD),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request latches, old-word capture for sub-word stores, and the load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (state_q == IDLE && bus.req) begin
                wr_q    <= bus.wr;
                f3_q    <= bus.funct3;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (state_q == READ) begin
                if (wr_q) old_q   <= bus.RD;
                else      rdata_q <= load_data;
            end
        end
    end

    // Next-state and output decode; all memory-side outputs are quiet outside READ/WRITE.
    always_comb begin
        state_d   = state_q;
        bus.busy  = (state_q != IDLE);
        bus.done  = 1'b0;
        bus.err   = 1'b0;
        bus.WE    = 1'b0;
        bus.WD    = 32'h0;
        bus.A     = '0;
        bus.rdata = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (!f3_legal(bus.wr, bus.funct3) ||
                        misaligned(bus.funct3[1:0], bus.addr[1:0]))
                        state_d = ERR;
                    else if (!bus.wr)
                        state_d = READ;
                    else if (bus.funct3 == F3_W)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus.A   = {addr_q[ADDR_W-1:2], 2'b00};
                state_d = wr_q ? WRITE : DONE;
            end
            WRITE: begin
                bus.A   = {addr_q[ADDR_W-1:2], 2'b00};
                bus.WE  = 1'b1;
                bus.WD  = merge_data;
                state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic clk;
    logic rst;

    lsu_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory attached to the unit (word index = A[9:2])
    logic [31:0] mem [0:255];
    always @(posedge clk) if (bus.WE) mem[bus.A[9:2]] <= bus.WD;
    assign bus.RD = mem[bus.A[9:2]];

    // reference state
    logic [31:0] model_mem [0:255];
    logic [31:0] model_rdata;

    typedef struct {
        logic        busy;
        logic        done;
        logic        err;
        logic        we;
        logic        chk_a;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic exp_t mk(input logic busy, input logic done, input logic err, input logic we,
                                input logic chk_a, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd);
        exp_t e;
        e.busy = busy; e.done = done; e.err = err; e.we = we;
        e.chk_a = chk_a; e.a = a; e.wd = wd; e.rd = rd;
        return e;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        longint v, span;
        span = 64'sd1 << (8 * nbytes(f3));
        v = longint'(w) >> (8 * int'(off));
        v = v % span;
        if (!f3[2] && nbytes(f3) < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
        longint mask, res;
        mask = ((64'sd1 << (8 * nbytes(f3))) - 1) << (8 * int'(off));
        res  = (longint'(old) & ~mask) | ((longint'(wd) << (8 * int'(off))) & mask);
        return res[31:0];
    endfunction

    // compare every cycle, 1 time unit after the active edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, model_rdata);
            chk("busy", {31'h0, bus.busy}, {31'h0, e.busy});
            chk("done", {31'h0, bus.done}, {31'h0, e.done});
            chk("err",  {31'h0, bus.err},  {31'h0, e.err});
            chk("WE",   {31'h0, bus.WE},   {31'h0, e.we});
            if (e.chk_a) chk("A", bus.A, e.a);
            if (e.we || !e.busy) chk("WD", bus.WD, e.wd);
            chk("rdata", bus.rdata, e.rd);
        end
    end

    // called at a falling edge; returns at the falling edge inside the following idle cycle
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] ad,
                         input logic [31:0] wd, input bit poke_busy);
        logic        legal, mis;
        logic [31:0] word;
        logic [7:0]  idx;
        logic [31:0] nv;
        int          lat;
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) || (!w && (f3 == 3'b100 || f3 == 3'b101));
        mis   = (nbytes(f3) == 2 && ad[0]) || (nbytes(f3) == 4 && ad[1:0] != 2'b00);
        word  = {ad[31:2], 2'b00};
        idx   = ad[9:2];
        bus.req = 1'b1; bus.wr = w; bus.funct3 = f3; bus.addr = ad; bus.wdata = wd;
        if (!legal || mis) begin
            exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, model_rdata));
            lat = 1;
        end else if (!w) begin
            nv = model_load(model_mem[idx], f3, ad[1:0]);
            exp_q.push_back(mk(1, 0, 0, 0, 1, word, 0, model_rdata));
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, nv));
            model_rdata = nv;
            lat = 2;
        end else if (f3 == 3'b010) begin
            exp_q.push_back(mk(1, 0, 0, 1, 1, word, wd, model_rdata));
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, model_rdata));
            model_mem[idx] = wd;
            lat = 2;
        end else begin
            nv = model_merge(model_mem[idx], wd, f3, ad[1:0]);
            exp_q.push_back(mk(1, 0, 0, 0, 1, word, 0, model_rdata));
            exp_q.push_back(mk(1, 0, 0, 1, 1, word, nv, model_rdata));
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, model_rdata));
            model_mem[idx] = nv;
            lat = 3;
        end
        @(negedge clk);
        if (poke_busy) begin
            bus.req = 1'b1; bus.wr = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0; bus.wdata = 32'hFFFF_FFFF;
        end else begin
            bus.req = 1'b0;
        end
        repeat (lat) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        model_rdata = 32'h0;
        rst = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
        #1;
        chk("reset busy",  {31'h0, bus.busy}, 32'h0);
        chk("reset done",  {31'h0, bus.done}, 32'h0);
        chk("reset WE",    {31'h0, bus.WE},   32'h0);
        chk("reset rdata", bus.rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(1, 3'b010, 32'd400, 32'h2B34_5FD4, 0);   // sw
        chk("pin sw mem", mem[100], 32'h2B34_5FD4);
        issue(0, 3'b010, 32'd400, 32'h0, 0);           // lw
        chk("pin lw", bus.rdata, 32'h2B34_5FD4);
        issue(1, 3'b000, 32'd401, 32'h1234_56AB, 0);   // sb
        chk("pin sb mem", mem[100], 32'h2B34_ABD4);
        issue(0, 3'b000, 32'd402, 32'h0, 1);           // lb, req poked while busy
        chk("pin lb", bus.rdata, 32'h0000_0034);
        issue(0, 3'b101, 32'd400, 32'h0, 0);           // lhu
        chk("pin lhu", bus.rdata, 32'h0000_ABD4);
        issue(0, 3'b001, 32'd400, 32'h0, 0);           // lh
        chk("pin lh", bus.rdata, 32'hFFFF_ABD4);
        issue(0, 3'b010, 32'd402, 32'h0, 0);           // misaligned lw
        issue(0, 3'b011, 32'd400, 32'h0, 1);           // illegal funct3
        issue(1, 3'b100, 32'd400, 32'h0, 0);           // store with BU code
        issue(1, 3'b001, 32'd401, 32'h0, 0);           // misaligned sh
        chk("pin err rdata", bus.rdata, 32'hFFFF_ABD4);
        chk("pin err mem", mem[100], 32'h2B34_ABD4);
        issue(1, 3'b001, 32'd402, 32'h7777_BEEF, 0);   // sh upper half
        chk("pin sh mem", mem[100], 32'hBEEF_ABD4);
        issue(0, 3'b000, 32'd403, 32'h0, 0);           // lb sign
        chk("pin lb neg", bus.rdata, 32'hFFFF_FFBE);
        issue(0, 3'b100, 32'd401, 32'h0, 0);           // lbu
        chk("pin lbu", bus.rdata, 32'h0000_00AB);

        // reset raised while WRITE is active
        bus.req = 1'b1; bus.wr = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'd400; bus.wdata = 32'hDEAD_BEEF;
        exp_q.push_back(mk(1, 0, 0, 1, 1, 32'd400, 32'hDEAD_BEEF, model_rdata));
        @(negedge clk);
        bus.req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst WE",    {31'h0, bus.WE},   32'h0);
        chk("rst busy",  {31'h0, bus.busy}, 32'h0);
        chk("rst done",  {31'h0, bus.done}, 32'h0);
        chk("rst A",     bus.A,  32'h0);
        chk("rst WD",    bus.WD, 32'h0);
        chk("rst rdata", bus.rdata, 32'h0);
        exp_q.delete();
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mem", mem[100], 32'hBEEF_ABD4);
        issue(0, 3'b010, 32'd400, 32'h0, 0);
        chk("pin post-rst lw", bus.rdata, 32'hBEEF_ABD4);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of core and memory address buses.
REQ-002 Port clk  input  1  single clock; every register updates on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port req  input  1  core access request, sampled only in IDLE.
REQ-005 Port wr  input  1  1 = store, 0 = load.
REQ-006 Port funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Port addr  input  ADDR_W  byte address.
REQ-008 Port wdata  input  32  store data, right-aligned.
REQ-009 Port rdata  output  32  extracted, extended load result.
REQ-010 Port done  output  1  one-cycle completion pulse.
REQ-011 Port err  output  1  misaligned or illegal access, valid while done=1.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port A  output  ADDR_W  word-aligned memory address: addr with bits [1:0] cleared.
REQ-014 Port WD  output  32  memory write data.
REQ-015 Port WE  output  1  memory write enable; the memory writes on the rising edge when WE=1.
REQ-016 Port RD  input  32  memory read data, combinational from A.

Function
REQ-017 FSM states: IDLE, READ, WRITE, DONE, ERR.
REQ-018 In IDLE, req=1 latches wr, funct3, addr and wdata, then transitions as follows:
  - illegal funct3 (011, 110, 111, or a store with 100/101) -> ERR;
  - misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> ERR;
  - load -> READ;
  - store word -> WRITE;
  - store byte or halfword -> READ.
REQ-019 READ holds A at the latched word address with WE=0 and captures RD at the closing edge:
  - load: extract the lane selected by addr[1:0], sign- or zero-extend into rdata, go to DONE;
  - sub-word store: keep the captured word as old data, go to WRITE.
REQ-020 WRITE holds WE=1 for exactly one cycle:
  - WD = wdata for a word store;
  - otherwise WD = old word with only the addressed byte/halfword lanes replaced by the low bits of wdata;
  - next state DONE.
REQ-021 DONE: done=1 and err=0 for one cycle, then IDLE.
REQ-022 ERR: done=1 and err=1 for one cycle, then IDLE; memory is never written.
REQ-023 Latency from the req-sampling edge to done high:
  - load 2 cycles;
  - word store 2 cycles;
  - sub-word store 3 cycles;
  - error 1 cycle.
REQ-024 req while busy=1 is ignored and is not queued.
REQ-025 WE=0 in all states except WRITE.
REQ-026 A=0 and WD=0 in IDLE.
REQ-027 rdata holds its last load value until the next load completes; stores and errors leave it unchanged.
REQ-028 The next req is accepted in the cycle after DONE or ERR (back-to-back, no dead cycle).

Reset
REQ-029 While reset=1, asynchronously: state=IDLE, rdata=0, done=0, err=0, busy=0, A=0, WD=0, WE=0.
REQ-030 reset asserted during WRITE drops WE immediately; that write is aborted and no done is produced.
REQ-031 The first req is sampled at the first rising edge after reset deasserts.

Structure
REQ-032 Shared package lsu_pkg holds the state enumeration and the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-033 Sub-module lsu_align (combinational) performs lane extraction/extension and store-lane merge; the FSM, latches and outputs live in load_store_unit.

Verification
REQ-034 Word store, then load: sw 0x2B345FD4 to addr 400 -> one WE pulse with A=400; lw from 400 -> rdata=0x2B345FD4, done two cycles after req.
REQ-035 Byte store: sb 0xAB to addr 401, memory holding 0x2B345FD4 -> a READ cycle, then WE with WD=0x2B34ABD4, done three cycles after req.
REQ-036 Sign/zero extension: lb at 402 of 0x2B34ABD4 -> rdata=0x00000034; lhu at 400 -> 0x0000ABD4; lh at 400 -> 0xFFFFABD4.
REQ-037 Errors: lw at addr 402, and funct3=011 -> done and err high one cycle after req, WE never asserted, rdata unchanged.
REQ-038 Robustness: req pulsed while busy -> ignored; reset raised mid-WRITE -> WE falls asynchronously and memory word 400 is unchanged.
